a5_1_core: RTL and testbench

- A5/1 keystream generator core, directly downstream of the Wishbone register interface inside the user-project macro.
- The interface block programs the 64-bit key and 22-bit frame number, then pulses start.
- The core runs key load, frame load and mixing, then streams keystream bits back through a valid/ready handshake.
- Three LFSRs with majority clocking, one bit per cycle.

---
 rtl/a5_1_core_if.sv | 36 +++
 rtl/a5_1_core.sv | 188 ++++++++++++++++++
 tb/tb_a5_1_core.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/a5_1_core_if.sv
// Handshake bundle between the Wishbone register block and the A5/1 core; word packer ports exist under A5_WORD_OUT_EN.
// Pure wiring, no latency.
// Backpressure flows over ks_ready from the consumer (master) to the core (slave).
interface a5_1_core_if;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy;
  logic        ks_valid;
  logic        ks_ready;
  logic        ks_bit;
  logic        ks_last;
  logic        done;
`ifdef A5_WORD_OUT_EN
  logic [31:0] ks_word;
  logic        ks_word_valid;

  modport master (
    output start, key, frame, ks_ready,
    input  busy, ks_valid, ks_bit, ks_last, done, ks_word, ks_word_valid
  );
  modport slave (
    input  start, key, frame, ks_ready,
    output busy, ks_valid, ks_bit, ks_last, done, ks_word, ks_word_valid
  );
`else
  modport master (
    output start, key, frame, ks_ready,
    input  busy, ks_valid, ks_bit, ks_last, done
  );
  modport slave (
    input  start, key, frame, ks_ready,
    output busy, ks_valid, ks_bit, ks_last, done
  );
`endif
endinterface

// File: rtl/a5_1_core.sv
// A5/1 keystream core: key/frame load, majority mixing, one keystream bit per handshake; A5_WORD_OUT_EN adds a 32-bit packer.
// Latency: first ks_valid 64+22+MIX_CYCLES+1 cycles after the accepted start.
// Backpressure: ks_ready low freezes the registers and ks_bit; nothing is dropped.
module a5_1_core #(
  parameter int KS_BITS    = 228,
  parameter int MIX_CYCLES = 100
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  a5_1_core_if.slave   bus
);

  localparam logic [9:0]  KS_LAST  = 10'(KS_BITS - 1);
  localparam logic [15:0] MIX_LAST = 16'(MIX_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_FRAME, MIX, RUN} state_t;

  state_t      state;
  logic [63:0] key_q;
  logic [21:0] frame_q;
  logic [18:0] r1;
  logic [21:0] r2;
  logic [22:0] r3;
  logic [9:0]  ks_cnt;
  logic [15:0] step_cnt;
  logic        busy_q;
  logic        ks_valid_q;
  logic        ks_last_q;
  logic        done_q;

  logic maj;
  logic step1, step2, step3;
  logic ks_bit;
  logic hs;

  function automatic logic [18:0] r1_step(input logic [18:0] r, input logic inj);
    return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18] ^ inj};
  endfunction

  function automatic logic [21:0] r2_step(input logic [21:0] r, input logic inj);
    return {r[20:0], r[20] ^ r[21] ^ inj};
  endfunction

  function automatic logic [22:0] r3_step(input logic [22:0] r, input logic inj);
    return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22] ^ inj};
  endfunction

  assign maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
  assign step1  = (r1[8]  == maj);
  assign step2  = (r2[10] == maj);
  assign step3  = (r3[10] == maj);
  assign ks_bit = r1[18] ^ r2[21] ^ r3[22];
  assign hs     = ks_valid_q & bus.ks_ready;

  assign bus.busy     = busy_q;
  assign bus.ks_valid = ks_valid_q;
  assign bus.ks_bit   = ks_bit;
  assign bus.ks_last  = ks_last_q;
  assign bus.done     = done_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      key_q      <= '0;
      frame_q    <= '0;
      r1         <= '0;
      r2         <= '0;
      r3         <= '0;
      ks_cnt     <= '0;
      step_cnt   <= '0;
      busy_q     <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            key_q    <= bus.key;
            frame_q  <= bus.frame;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            ks_cnt   <= '0;
            step_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= LOAD_KEY;
          end
        end
        LOAD_KEY: begin
          r1 <= r1_step(r1, key_q[step_cnt[5:0]]);
          r2 <= r2_step(r2, key_q[step_cnt[5:0]]);
          r3 <= r3_step(r3, key_q[step_cnt[5:0]]);
          if (step_cnt == 16'd63) begin
            step_cnt <= '0;
            state    <= LOAD_FRAME;
          end else begin
            step_cnt <= step_cnt + 16'd1;
          end
        end
        LOAD_FRAME: begin
          r1 <= r1_step(r1, frame_q[step_cnt[4:0]]);
          r2 <= r2_step(r2, frame_q[step_cnt[4:0]]);
          r3 <= r3_step(r3, frame_q[step_cnt[4:0]]);
          if (step_cnt == 16'd21) begin
            step_cnt <= '0;
            state    <= MIX;
          end else begin
            step_cnt <= step_cnt + 16'd1;
          end
        end
        MIX: begin
          if (step1) r1 <= r1_step(r1, 1'b0);
          if (step2) r2 <= r2_step(r2, 1'b0);
          if (step3) r3 <= r3_step(r3, 1'b0);
          // The final mixing step leaves keystream bit 0 on the register taps.
          if (step_cnt == MIX_LAST) begin
            ks_valid_q <= 1'b1;
            ks_last_q  <= (KS_LAST == 10'd0);
            state      <= RUN;
          end else begin
            step_cnt <= step_cnt + 16'd1;
          end
        end
        RUN: begin
          if (hs) begin
            if (ks_cnt == KS_LAST) begin
              ks_valid_q <= 1'b0;
              ks_last_q  <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state      <= IDLE;
            end else begin
              if (step1) r1 <= r1_step(r1, 1'b0);
              if (step2) r2 <= r2_step(r2, 1'b0);
              if (step3) r3 <= r3_step(r3, 1'b0);
              ks_cnt    <= ks_cnt + 10'd1;
              ks_last_q <= ((ks_cnt + 10'd1) == KS_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef A5_WORD_OUT_EN
  logic [31:0] pack_sr;
  logic [4:0]  pack_cnt;
  logic [31:0] word_q;
  logic        word_vld_q;
  logic [31:0] pack_next;

  // MSB-first: bit n of a word lands at position 31-n, unused tail stays zero.
  assign pack_next = pack_sr | ({31'd0, ks_bit} << (5'd31 - pack_cnt));

  assign bus.ks_word       = word_q;
  assign bus.ks_word_valid = word_vld_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pack_sr    <= '0;
      pack_cnt   <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_vld_q <= 1'b0;
      if (state == IDLE && bus.start) begin
        pack_sr  <= '0;
        pack_cnt <= '0;
        word_q   <= '0;
      end else if (hs) begin
        if (pack_cnt == 5'd31 || ks_cnt == KS_LAST) begin
          word_q     <= pack_next;
          word_vld_q <= 1'b1;
          pack_sr    <= '0;
          pack_cnt   <= '0;
        end else begin
          pack_sr  <= pack_next;
          pack_cnt <= pack_cnt + 5'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_a5_1_core.sv
// Randomized self-checking bench for a5_1_core against a mask-based A5/1 reference model.
// Covers the known GSM vector, latency, backpressure, ignored start, mid-run reset and the optional word packer.
module tb_a5_1_core;

  localparam int KS  = 228;
  localparam int MIX = 100;
  localparam logic [63:0] KEY0 = 64'hEFCDAB8967452312;
  localparam logic [21:0] FR0  = 22'h134;

  logic clk = 1'b0;
  logic rst;

  a5_1_core_if bus ();

  a5_1_core #(.KS_BITS(KS), .MIX_CYCLES(MIX)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  bit exp_bits [KS];
  bit got_bits [KS];
  int idx;
  int done_seen;
  bit hold_prev;
  bit prev_bit;
  int wcnt;
  logic [31:0] first_word;
  logic [31:0] last_word;
  logic [31:0] exp_w;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int unsigned shift_reg(input int unsigned r, input int unsigned mask,
                                            input int unsigned taps);
    return ((r << 1) & mask) | int'(^(r & taps));
  endfunction

  // Reference generator in the style of the published C model: step, then read the output taps.
  task automatic model_gen(input logic [63:0] k, input logic [21:0] f);
    int unsigned a, b, c;
    int unsigned nclk;
    a = 0; b = 0; c = 0;
    for (int i = 0; i < 86; i++) begin
      a = shift_reg(a, 32'h7FFFF,  32'h72000);
      b = shift_reg(b, 32'h3FFFFF, 32'h300000);
      c = shift_reg(c, 32'h7FFFFF, 32'h700080);
      if (i < 64 ? k[i] : f[i-64]) begin
        a ^= 1; b ^= 1; c ^= 1;
      end
    end
    for (int i = 0; i < MIX + KS; i++) begin
      nclk = ((a >> 8) & 1) + ((b >> 10) & 1) + ((c >> 10) & 1);
      if (((a >> 8) & 1) == (nclk >= 2 ? 1 : 0))  a = shift_reg(a, 32'h7FFFF,  32'h72000);
      if (((b >> 10) & 1) == (nclk >= 2 ? 1 : 0)) b = shift_reg(b, 32'h3FFFFF, 32'h300000);
      if (((c >> 10) & 1) == (nclk >= 2 ? 1 : 0)) c = shift_reg(c, 32'h7FFFFF, 32'h700080);
      if (i >= MIX) exp_bits[i-MIX] = bit'(((a >> 18) ^ (b >> 21) ^ (c >> 22)) & 1);
    end
  endtask

  function automatic logic [119:0] pack_exp(input int base);
    logic [119:0] v;
    v = '0;
    for (int i = 0; i < 114; i++) v[119-i] = exp_bits[base+i];
    return v;
  endfunction

  function automatic logic [119:0] pack_got(input int base);
    logic [119:0] v;
    v = '0;
    for (int i = 0; i < 114; i++) v[119-i] = got_bits[base+i];
    return v;
  endfunction

  // Single compare process: checks every valid keystream cycle against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.start && !bus.busy) begin
        idx = 0; done_seen = 0; hold_prev = 0; wcnt = 0;
      end
      if (bus.done) done_seen++;
      if (bus.ks_valid) begin
        if (idx >= KS) begin
          chk("overrun_idx", 128'(idx), 128'(KS - 1));
        end else begin
          chk("ks_bit", 128'(bus.ks_bit), 128'(exp_bits[idx]));
          chk("ks_last", 128'(bus.ks_last), 128'(idx == KS - 1));
          if (hold_prev) chk("hold_stable", 128'(bus.ks_bit), 128'(prev_bit));
          if (bus.ks_ready) begin
            got_bits[idx] = bus.ks_bit;
            idx++;
            hold_prev = 0;
          end else begin
            hold_prev = 1;
            prev_bit  = bus.ks_bit;
          end
        end
      end
`ifdef A5_WORD_OUT_EN
      if (bus.ks_word_valid) begin
        exp_w = '0;
        for (int j = 0; j < 32; j++)
          if (32 * wcnt + j < KS) exp_w[31-j] = exp_bits[32*wcnt+j];
        chk("ks_word", 128'(bus.ks_word), 128'(exp_w));
        if (wcnt == 0) first_word = bus.ks_word;
        last_word = bus.ks_word;
        wcnt++;
      end
`endif
    end
  end

  // mode: 0 = ks_ready held high, 1 = random ks_ready.
  task automatic run_one(input logic [63:0] k, input logic [21:0] f, input int mode,
                         input bit mid_start, input int abort_at);
    int cyc;
    int n;
    bit aborted;
    aborted = 0;
    bus.key = k; bus.frame = f; bus.start = 1'b1;
    bus.ks_ready = (mode == 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.ks_valid && cyc < 400) begin
      chk("busy_during_load", 128'(bus.busy), 128'd1);
      if (mid_start && cyc == 10) begin
        bus.key = ~k; bus.frame = ~f; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (mode == 1) bus.ks_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("first_valid_latency", 128'(cyc), 128'(64 + 22 + MIX + 1));
    n = 0;
    while ((bus.busy || bus.ks_valid) && n < 5000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_valid", 128'(bus.ks_valid), 128'd0);
        chk("abort_last", 128'(bus.ks_last), 128'd0);
        chk("abort_done", 128'(bus.done), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
      chk("busy_during_run", 128'(bus.busy), 128'd1);
      bus.ks_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) chk("run_timeout", 128'(n), 128'd0);
    repeat (4) @(posedge clk);
    #1;
    if (aborted) begin
      chk("abort_no_done", 128'(done_seen), 128'd0);
      chk("abort_idx", 128'(idx), 128'(abort_at));
    end else begin
      chk("bits_taken", 128'(idx), 128'(KS));
      chk("done_once", 128'(done_seen), 128'd1);
      chk("idle_after", 128'(bus.busy), 128'd0);
    end
  endtask

  initial begin
    logic [63:0] rk;
    logic [21:0] rf;
    rst = 1'b1;
    bus.start = 1'b0; bus.key = '0; bus.frame = '0; bus.ks_ready = 1'b0;
    idx = 0; done_seen = 0; hold_prev = 0; prev_bit = 0; wcnt = 0;
    first_word = '0; last_word = '0; exp_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_valid", 128'(bus.ks_valid), 128'd0);
    chk("reset_bit", 128'(bus.ks_bit), 128'd0);
    chk("reset_last", 128'(bus.ks_last), 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    model_gen(KEY0, FR0);
    chk("model_a_to_b", 128'(pack_exp(0)),   128'(120'h534EAA582FE8151AB6E1855A728C00));
    chk("model_b_to_a", 128'(pack_exp(114)), 128'(120'h24FD35A35D5FB6526D32F906DF1AC0));

    run_one(KEY0, FR0, 0, 1'b0, -1);
    chk("vec_a_to_b", 128'(pack_got(0)),   128'(120'h534EAA582FE8151AB6E1855A728C00));
    chk("vec_b_to_a", 128'(pack_got(114)), 128'(120'h24FD35A35D5FB6526D32F906DF1AC0));
`ifdef A5_WORD_OUT_EN
    chk("word_first", 128'(first_word), 128'(32'h534EAA58));
    chk("word_count", 128'(wcnt), 128'd8);
    chk("word_tail_zero", 128'(last_word[27:0]), 128'd0);
`endif

    run_one(KEY0, FR0, 1, 1'b0, -1);
    chk("bp_a_to_b", 128'(pack_got(0)), 128'(120'h534EAA582FE8151AB6E1855A728C00));

    run_one(KEY0, FR0, 0, 1'b1, -1);
    chk("midstart_b_to_a", 128'(pack_got(114)), 128'(120'h24FD35A35D5FB6526D32F906DF1AC0));

    run_one(KEY0, FR0, 0, 1'b0, 50);
    run_one(KEY0, FR0, 0, 1'b0, -1);
    chk("after_abort_a_to_b", 128'(pack_got(0)), 128'(120'h534EAA582FE8151AB6E1855A728C00));

    for (int t = 0; t < 3; t++) begin
      rk = {$urandom, $urandom};
      rf = 22'($urandom);
      model_gen(rk, rf);
      run_one(rk, rf, 1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
